dp_sequencer: RTL and testbench
===============================

// Module: dp_sequencer
// PURPOSE
//  Multi-cycle controller for the ARM data-processing datapath. Accepts one decoded
//  data-processing instruction per handshake and drives the datapath's control inputs:
//  operand load, shift, ALU op, status update, Rd/PC write-back. Sits between decode
//  and the datapath; one instruction in flight.
// PARAMETERS
//  PC_W     11  width of PC / dp_pc path
//  IMM_W    32  width of imme_data / shift_imme
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous reset, active-high
//  instr_valid    in   1   decoded instruction present
//  instr_ready    out  1   sequencer can accept (IDLE only)
//  cond           in   4   ARM condition field
//  opcode         in   4   ARM DP opcode (ADD,SUB,AND,ORR,EOR,MOV,CMP,TST)
//  s_bit          in   1   update flags
//  i_bit          in   1   operand2 is immediate
//  reg_shift      in   1   shift amount from Rs (else shift_imm)
//  rn,rd,rm,rs    in   4ea register addresses
//  shift_type     in   2   LSL/LSR/ASR/ROR
//  shift_imm      in   5   immediate shift amount
//  imm32          in   32  expanded immediate operand
//  flags          in   4   NZCV from datapath status_out[31:28]
//  A_addr,B_addr,shift_addr out 4 regfile read addresses
//  en_A,en_B,en_S out  1   operand register enables
//  sel_A,sel_B,sel_shift out 1  datapath operand muxes
//  shift_op       out  2   shifter op;  shift_imme out 32 zero-extended shift_imm
//  imme_data      out  32  immediate operand;  ALU_op out 3
//  w_addr2,w_en2  out 4,1  ALU result write-back
//  en_status,status_rdy out 1  flag register update
//  sel_pc out 2, load_pc out 1  PC load from dp_pc
//  done           out  1   one-cycle completion pulse
//  executed       out  1   valid with done: 0 = condition failed
//  illegal        out  1   one-cycle pulse: unsupported opcode, dropped
// BEHAVIOUR
//  - Reset: state IDLE; instr_ready=1; all enables/pulses 0; selects 0; ALU_op=ADD.
//  - Handshake: accept when instr_valid&instr_ready; fields latched at accept;
//    instr_ready=0 until return to IDLE.
//  - States: IDLE -> LOAD -> EXEC -> IDLE; EXEC -> FLUSH -> IDLE when rd==15 & written.
//  - LOAD: A_addr=rn, B_addr=rm, shift_addr=rs; en_A=en_B=en_S=1; sel_shift=reg_shift.
//  - EXEC: sel_B=i_bit; sel_A=1 for MOV (0+B); ALU_op per package table;
//    CMP=SUB, TST=AND with w_en2=0; else w_en2=1, w_addr2=rd;
//    en_status=status_rdy=s_bit|CMP|TST.
//  - Latency: accept T, LOAD T+1, EXEC T+2, done T+2, next accept T+3.
//  - rd==15 write: w_en2=0; load_pc=1, sel_pc=PC_SEL_DP in EXEC; FLUSH 1 cycle;
//    done at T+3.
//  - Illegal opcode (RSB/ADC/etc.): illegal pulses in LOAD; done=0; back to IDLE, no writes.
//  - Reset mid-instruction: abort to IDLE same edge, no write/flag/PC side effects after.
//  - Flags sampled in LOAD (prior instruction fully retired).
// CONFIGURATION
//  - DP_SEQ_COND_EN defined: cond evaluated vs flags in LOAD (EQ..AL, NV=never);
//    fail -> done=1, executed=0 at T+1, no EXEC, no writes.
//  - Undefined: cond ignored, all instructions execute, executed=done.
// STRUCTURE
//  - Shared package dp_pkg: opcode enum, ALU_op codes (ADD=0,SUB=1,AND=2,ORR=3,EOR=4),
//    shift_op codes, PC_SEL_* constants, cond enum, state enum.
//  - One sub-module: cond_check (combinational cond x NZCV -> pass), only under DP_SEQ_COND_EN.
// TESTING
//  - ADD rd=2,rn=0,rm=1,i=0,LSL#0: LOAD en_A/B/S at T+1; EXEC ALU_op=0, w_en2=1, w_addr2=2, done T+2.
//  - MOV rd=3,i=1,imm32=0x55: sel_A=1, sel_B=1, imme_data=0x55, en_status=0 (s=0).
//  - CMP rn=4,rm=5: ALU_op=SUB, w_en2=0, en_status=1, status_rdy=1.
//  - ADD rd=15: load_pc=1, sel_pc=PC_SEL_DP in EXEC, w_en2=0, done T+3.
//  - COND_EN, EQ with flags Z=0: done=1, executed=0 at T+1, no en_status/w_en2/load_pc.
//  - rst high during EXEC: next cycle IDLE, instr_ready=1, no done; back-to-back valid accepted.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types and decode helpers for the data-processing sequencer.
package dp_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned ALU_OP_W   = 3;
  localparam int unsigned SHIFT_OP_W = 2;
  localparam int unsigned PC_SEL_W   = 2;
  localparam int unsigned COND_W     = 4;
  localparam int unsigned FLAGS_W    = 4;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned SH_IMM_W   = 5;
  localparam int unsigned IMM32_W    = 32;

  localparam logic [REG_ADDR_W-1:0] PC_REG = 4'hF;

  // ARM data-processing opcode field
  typedef enum logic [OPCODE_W-1:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } opcode_e;

  // Datapath ALU operation codes
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_ORR = 3'd3, ALU_EOR = 3'd4
  } alu_op_e;

  // Barrel shifter operation codes
  typedef enum logic [SHIFT_OP_W-1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_op_e;

  // PC load source select
  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEL_SEQ = 2'd0, PC_SEL_BR = 2'd1, PC_SEL_DP = 2'd2
  } pc_sel_e;

  // ARM condition field
  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_EXEC = 2'd2, ST_FLUSH = 2'd3
  } state_e;

  // Decoded instruction captured at the handshake
  typedef struct packed {
    logic [COND_W-1:0]     cond;
    opcode_e               opcode;
    logic                  s_bit;
    logic                  i_bit;
    logic                  reg_shift;
    logic [REG_ADDR_W-1:0] rn;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rm;
    logic [REG_ADDR_W-1:0] rs;
    shift_op_e             shift_type;
    logic [SH_IMM_W-1:0]   shift_imm;
    logic [IMM32_W-1:0]    imm32;
  } dp_instr_t;

  // Opcodes the datapath can execute
  function automatic logic op_legal(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_CMP, OP_TST: op_legal = 1'b1;
      default:                                                        op_legal = 1'b0;
    endcase
  endfunction

  // Opcode to ALU operation; MOV adds B to a zeroed A, compares reuse SUB/AND
  function automatic alu_op_e alu_op_of(input opcode_e op);
    case (op)
      OP_SUB, OP_CMP: alu_op_of = ALU_SUB;
      OP_AND, OP_TST: alu_op_of = ALU_AND;
      OP_ORR:         alu_op_of = ALU_ORR;
      OP_EOR:         alu_op_of = ALU_EOR;
      default:        alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluation against NZCV; only built when DP_SEQ_COND_EN is defined.
`ifdef DP_SEQ_COND_EN
module cond_check
  import dp_pkg::*;
(
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               pass_c
);

  logic n, z, c, v;
  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  // Condition truth table; NV never passes
  always_comb begin
    pass_c = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass_c = z;
      COND_NE: pass_c = ~z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = ~c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = ~n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = ~v;
      COND_HI: pass_c = c & ~z;
      COND_LS: pass_c = ~c | z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = ~z & (n == v);
      COND_LE: pass_c = z | (n != v);
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/dp_sequencer.sv
// Multi-cycle controller for the data-processing datapath: IDLE -> LOAD -> EXEC
// (-> FLUSH on a PC write) -> IDLE, one instruction in flight.
// Define DP_SEQ_COND_EN to evaluate the condition field against flags in LOAD;
// otherwise every legal instruction executes.
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int unsigned PC_W  = 11,
  parameter int unsigned IMM_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [COND_W-1:0]     cond,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  s_bit,
  input  logic                  i_bit,
  input  logic                  reg_shift,
  input  logic [REG_ADDR_W-1:0] rn,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rm,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [SHIFT_OP_W-1:0] shift_type,
  input  logic [SH_IMM_W-1:0]   shift_imm,
  input  logic [IMM32_W-1:0]    imm32,
  input  logic [FLAGS_W-1:0]    flags,
  output logic [REG_ADDR_W-1:0] A_addr,
  output logic [REG_ADDR_W-1:0] B_addr,
  output logic [REG_ADDR_W-1:0] shift_addr,
  output logic                  en_A,
  output logic                  en_B,
  output logic                  en_S,
  output logic                  sel_A,
  output logic                  sel_B,
  output logic                  sel_shift,
  output logic [SHIFT_OP_W-1:0] shift_op,
  output logic [IMM_W-1:0]      shift_imme,
  output logic [IMM_W-1:0]      imme_data,
  output logic [ALU_OP_W-1:0]   ALU_op,
  output logic [REG_ADDR_W-1:0] w_addr2,
  output logic                  w_en2,
  output logic                  en_status,
  output logic                  status_rdy,
  output logic [PC_SEL_W-1:0]   sel_pc,
  output logic                  load_pc,
  output logic                  done,
  output logic                  executed,
  output logic                  illegal
);

  state_e    state_q, state_d;
  dp_instr_t instr_q, instr_d;

  logic cond_pass_c;
  logic is_cmp_tst;
  logic wr_pc;
  logic upd_flags;
  logic unused_ok;

`ifdef DP_SEQ_COND_EN
  cond_check u_cond_check (
    .cond   (instr_q.cond),
    .flags  (flags),
    .pass_c (cond_pass_c)
  );
  assign unused_ok = ^{1'(PC_W)};
`else
  assign cond_pass_c = 1'b1;
  assign unused_ok   = ^{instr_q.cond, flags, 1'(PC_W)};
`endif

  assign is_cmp_tst = (instr_q.opcode == OP_CMP) || (instr_q.opcode == OP_TST);
  assign wr_pc      = !is_cmp_tst && (instr_q.rd == PC_REG);
  assign upd_flags  = instr_q.s_bit | is_cmp_tst;

  // State and captured-instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Next state and datapath control decode
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_ready = 1'b0;
    A_addr      = '0;
    B_addr      = '0;
    shift_addr  = '0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_S        = 1'b0;
    sel_A       = 1'b0;
    sel_B       = 1'b0;
    sel_shift   = 1'b0;
    shift_op    = '0;
    shift_imme  = '0;
    imme_data   = '0;
    ALU_op      = ALU_ADD;
    w_addr2     = '0;
    w_en2       = 1'b0;
    en_status   = 1'b0;
    status_rdy  = 1'b0;
    sel_pc      = PC_SEL_SEQ;
    load_pc     = 1'b0;
    done        = 1'b0;
    executed    = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d.cond       = cond;
          instr_d.opcode     = opcode_e'(opcode);
          instr_d.s_bit      = s_bit;
          instr_d.i_bit      = i_bit;
          instr_d.reg_shift  = reg_shift;
          instr_d.rn         = rn;
          instr_d.rd         = rd;
          instr_d.rm         = rm;
          instr_d.rs         = rs;
          instr_d.shift_type = shift_op_e'(shift_type);
          instr_d.shift_imm  = shift_imm;
          instr_d.imm32      = imm32;
          state_d            = ST_LOAD;
        end
      end

      ST_LOAD: begin
        A_addr     = instr_q.rn;
        B_addr     = instr_q.rm;
        shift_addr = instr_q.rs;
        en_A       = 1'b1;
        en_B       = 1'b1;
        en_S       = 1'b1;
        sel_shift  = instr_q.reg_shift;
        shift_op   = instr_q.shift_type;
        shift_imme = IMM_W'(instr_q.shift_imm);
        imme_data  = IMM_W'(instr_q.imm32);
        if (!op_legal(instr_q.opcode)) begin
          illegal = 1'b1;
          state_d = ST_IDLE;
        end else if (!cond_pass_c) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        sel_shift  = instr_q.reg_shift;
        shift_op   = instr_q.shift_type;
        shift_imme = IMM_W'(instr_q.shift_imm);
        imme_data  = IMM_W'(instr_q.imm32);
        sel_A      = (instr_q.opcode == OP_MOV);
        sel_B      = instr_q.i_bit;
        ALU_op     = alu_op_of(instr_q.opcode);
        w_addr2    = instr_q.rd;
        w_en2      = !is_cmp_tst && !wr_pc;
        en_status  = upd_flags;
        status_rdy = upd_flags;
        if (wr_pc) begin
          load_pc = 1'b1;
          sel_pc  = PC_SEL_DP;
          state_d = ST_FLUSH;
        end else begin
          done     = 1'b1;
          executed = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        done     = 1'b1;
        executed = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A reset edge must not also commit a write, flag update or PC load
    if (rst) begin
      instr_ready = 1'b0;
      w_en2       = 1'b0;
      en_status   = 1'b0;
      status_rdy  = 1'b0;
      load_pc     = 1'b0;
      done        = 1'b0;
      executed    = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench for dp_sequencer: stimulus queues expected responses, a
// negedge monitor pops and compares on each done/illegal.
module tb_dp_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  cond, opcode;
  logic        s_bit, i_bit, reg_shift;
  logic [3:0]  rn, rd, rm, rs;
  logic [1:0]  shift_type;
  logic [4:0]  shift_imm;
  logic [31:0] imm32;
  logic [3:0]  flags;
  logic [3:0]  A_addr, B_addr, shift_addr;
  logic        en_A, en_B, en_S, sel_A, sel_B, sel_shift;
  logic [1:0]  shift_op;
  logic [31:0] shift_imme, imme_data;
  logic [2:0]  ALU_op;
  logic [3:0]  w_addr2;
  logic        w_en2, en_status, status_rdy;
  logic [1:0]  sel_pc;
  logic        load_pc, done, executed, illegal;

  dp_sequencer #(.PC_W(11), .IMM_W(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .cond(cond), .opcode(opcode), .s_bit(s_bit), .i_bit(i_bit), .reg_shift(reg_shift),
    .rn(rn), .rd(rd), .rm(rm), .rs(rs), .shift_type(shift_type), .shift_imm(shift_imm),
    .imm32(imm32), .flags(flags), .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
    .en_A(en_A), .en_B(en_B), .en_S(en_S), .sel_A(sel_A), .sel_B(sel_B), .sel_shift(sel_shift),
    .shift_op(shift_op), .shift_imme(shift_imme), .imme_data(imme_data), .ALU_op(ALU_op),
    .w_addr2(w_addr2), .w_en2(w_en2), .en_status(en_status), .status_rdy(status_rdy),
    .sel_pc(sel_pc), .load_pc(load_pc), .done(done), .executed(executed), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          exs;
    logic [2:0]  alu;
    bit          w;
    logic [3:0]  wa;
    bit          st;
    bit          pc;
    bit          sa;
    bit          sb;
    logic [31:0] imm;
    int          lat;
    bit          exd;
    bit          ill;
    logic [3:0]  a, b, s;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   stim_done = 0;

  int   cyc = 0, acc = 0, ph = 0;
  bit   busy = 0, rst_last = 0, ex_seen = 0;
  logic [3:0]  ld_a, ld_b, ld_s;
  logic        ld_en;
  logic [2:0]  x_alu;
  logic        x_w, x_st, x_rdy, x_pc, x_sa, x_sb;
  logic [3:0]  x_wa;
  logic [1:0]  x_selpc;
  logic [31:0] x_imm;

  function automatic exp_t mk(input string nm, input bit exs, input logic [2:0] alu,
                              input bit w, input logic [3:0] wa, input bit st, pc, sa, sb,
                              input logic [31:0] imm, input int lat, input bit exd, ill,
                              input logic [3:0] a, b, s);
    exp_t e;
    e.name = nm; e.exs = exs; e.alu = alu; e.w = w; e.wa = wa; e.st = st; e.pc = pc;
    e.sa = sa; e.sb = sb; e.imm = imm; e.lat = lat; e.exd = exd; e.ill = ill;
    e.a = a; e.b = b; e.s = s;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic end_check(input int p);
    exp_t e;
    busy = 0;
    if (q.size() == 0) begin
      chk("unexpected_end", 64'(q.size()), 64'(1));
      return;
    end
    e = q.pop_front();
    chk({e.name, ".latency"}, 64'(p), 64'(e.lat));
    chk({e.name, ".done_illegal"}, 64'({done, illegal}), 64'({!e.ill, e.ill}));
    if (!e.ill) chk({e.name, ".executed"}, 64'(executed), 64'(e.exd));
    chk({e.name, ".exec_seen"}, 64'(ex_seen), 64'(e.exs));
    chk({e.name, ".load"}, 64'({ld_a, ld_b, ld_s, ld_en}), 64'({e.a, e.b, e.s, 1'b1}));
    if (e.exs && ex_seen) begin
      chk({e.name, ".alu_op"},    64'(x_alu),   64'(e.alu));
      chk({e.name, ".w_en2"},     64'(x_w),     64'(e.w));
      chk({e.name, ".w_addr2"},   64'(x_wa),    64'(e.wa));
      chk({e.name, ".en_status"}, 64'(x_st),    64'(e.st));
      chk({e.name, ".status_rdy"},64'(x_rdy),   64'(e.st));
      chk({e.name, ".load_pc"},   64'(x_pc),    64'(e.pc));
      chk({e.name, ".sel_pc"},    64'(x_selpc), 64'(e.pc ? 2'd2 : 2'd0));
      chk({e.name, ".sel_A"},     64'(x_sa),    64'(e.sa));
      chk({e.name, ".sel_B"},     64'(x_sb),    64'(e.sb));
      chk({e.name, ".imme_data"}, 64'(x_imm),   64'(e.imm));
    end
  endtask

  // Monitor: sample mid-cycle, snapshot LOAD/EXEC controls, score at completion
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (stim_done) begin
        chk("drain", 64'(q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
      end
      if (rst) begin
        busy     = 0;
        rst_last = 1;
      end else begin
        if (rst_last) begin
          rst_last = 0;
          chk("post_reset.ready", 64'(instr_ready), 64'(1));
          chk("post_reset.ctl", 64'({done, illegal, w_en2, en_status, load_pc, en_A, en_B,
                                     en_S, sel_A, sel_B, sel_shift}), 64'(0));
          chk("post_reset.alu_sel_pc", 64'({ALU_op, sel_pc}), 64'(0));
        end
        if (busy) begin
          ph = cyc - acc;
          if (ph == 1) begin
            ld_a = A_addr; ld_b = B_addr; ld_s = shift_addr; ld_en = en_A & en_B & en_S;
          end
          if (!ex_seen && (w_en2 || en_status || load_pc)) begin
            ex_seen = 1;
            x_alu = ALU_op; x_w = w_en2; x_wa = w_addr2; x_st = en_status; x_rdy = status_rdy;
            x_pc = load_pc; x_selpc = sel_pc; x_sa = sel_A; x_sb = sel_B; x_imm = imme_data;
          end
          if (done || illegal) begin
            end_check(ph);
          end else if (ph > 6) begin
            chk("completion_timeout", 64'(ph), 64'(3));
            busy = 0;
            if (q.size() != 0) void'(q.pop_front());
          end
        end else begin
          chk("idle_strobes", 64'({done, illegal, w_en2, en_status, load_pc}), 64'(0));
        end
        if (instr_valid && instr_ready) begin
          busy = 1; acc = cyc; ex_seen = 0;
          ld_a = 'x; ld_b = 'x; ld_s = 'x; ld_en = 1'b0;
        end
      end
    end
  end

  task automatic setf(input logic [3:0] c, op, input bit s, i, rsh,
                      input logic [3:0] n_, d_, m_, s_, input logic [1:0] sht,
                      input logic [4:0] shm, input logic [31:0] imm, input logic [3:0] flg);
    cond = c; opcode = op; s_bit = s; i_bit = i; reg_shift = rsh;
    rn = n_; rd = d_; rm = m_; rs = s_; shift_type = sht; shift_imm = shm;
    imm32 = imm; flags = flg;
  endtask

  task automatic send(input exp_t e, input bit push);
    int n;
    bit got;
    if (push) q.push_back(e);
    instr_valid = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      got = instr_ready;
      @(posedge clk);
      #1;
      n = n + 1;
    end
    if (!got) begin
      $display("FAIL %s: instruction never accepted (instr_ready stuck at 0)", e.name);
      $fatal(1);
    end
    instr_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    instr_valid = 1'b0;
    setf(4'hE, 4'h4, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 5'd0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // name exs alu w wa st pc sa sb imm lat exd ill a b s
    setf(4'hE, 4'h4, 0, 0, 0, 4'd0, 4'd2, 4'd1, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("add", 1, 3'd0, 1, 4'd2, 0, 0, 0, 0, 32'h0, 2, 1, 0, 4'd0, 4'd1, 4'd0), 1);
    setf(4'hE, 4'hD, 0, 1, 0, 4'd0, 4'd3, 4'd0, 4'd0, 2'd0, 5'd0, 32'h55, 4'h0);
    send(mk("mov_imm", 1, 3'd0, 1, 4'd3, 0, 0, 1, 1, 32'h55, 2, 1, 0, 4'd0, 4'd0, 4'd0), 1);
    setf(4'hE, 4'hA, 0, 0, 0, 4'd4, 4'd0, 4'd5, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("cmp", 1, 3'd1, 0, 4'd0, 1, 0, 0, 0, 32'h0, 2, 1, 0, 4'd4, 4'd5, 4'd0), 1);
    setf(4'hE, 4'h4, 0, 0, 0, 4'd1, 4'd15, 4'd2, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("add_pc", 1, 3'd0, 0, 4'd15, 0, 1, 0, 0, 32'h0, 3, 1, 0, 4'd1, 4'd2, 4'd0), 1);
    setf(4'hE, 4'h0, 1, 0, 0, 4'd3, 4'd6, 4'd4, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("and_s", 1, 3'd2, 1, 4'd6, 1, 0, 0, 0, 32'h0, 2, 1, 0, 4'd3, 4'd4, 4'd0), 1);
    setf(4'hE, 4'hC, 0, 1, 0, 4'd5, 4'd7, 4'd0, 4'd0, 2'd0, 5'd0, 32'hF0, 4'h0);
    send(mk("orr_imm", 1, 3'd3, 1, 4'd7, 0, 0, 0, 1, 32'hF0, 2, 1, 0, 4'd5, 4'd0, 4'd0), 1);
    setf(4'hE, 4'h1, 0, 0, 0, 4'd2, 4'd8, 4'd3, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("eor", 1, 3'd4, 1, 4'd8, 0, 0, 0, 0, 32'h0, 2, 1, 0, 4'd2, 4'd3, 4'd0), 1);
    setf(4'hE, 4'h8, 0, 0, 0, 4'd9, 4'd0, 4'd10, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("tst", 1, 3'd2, 0, 4'd0, 1, 0, 0, 0, 32'h0, 2, 1, 0, 4'd9, 4'd10, 4'd0), 1);
    setf(4'hE, 4'h2, 1, 0, 1, 4'd11, 4'd11, 4'd13, 4'd12, 2'd2, 5'd7, 32'h0, 4'h0);
    send(mk("sub_rs", 1, 3'd1, 1, 4'd11, 1, 0, 0, 0, 32'h0, 2, 1, 0, 4'd11, 4'd13, 4'd12), 1);
    setf(4'hE, 4'h3, 0, 0, 0, 4'd1, 4'd4, 4'd2, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("rsb_illegal", 0, 3'd0, 0, 4'd0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 4'd1, 4'd2, 4'd0), 1);

    // EQ with Z=0
    setf(4'h0, 4'h4, 0, 0, 0, 4'd6, 4'd5, 4'd7, 4'd0, 2'd0, 5'd0, 32'h0, 4'b0000);
`ifdef DP_SEQ_COND_EN
    send(mk("eq_fail", 0, 3'd0, 0, 4'd0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 4'd6, 4'd7, 4'd0), 1);
`else
    send(mk("eq_ignored", 1, 3'd0, 1, 4'd5, 0, 0, 0, 0, 32'h0, 2, 1, 0, 4'd6, 4'd7, 4'd0), 1);
`endif
    // NE with Z=0 and EQ with Z=1 both pass
    setf(4'h1, 4'h4, 0, 0, 0, 4'd1, 4'd9, 4'd2, 4'd0, 2'd0, 5'd0, 32'h0, 4'b0000);
    send(mk("ne_pass", 1, 3'd0, 1, 4'd9, 0, 0, 0, 0, 32'h0, 2, 1, 0, 4'd1, 4'd2, 4'd0), 1);
    setf(4'h0, 4'h4, 0, 0, 0, 4'd3, 4'd10, 4'd4, 4'd0, 2'd0, 5'd0, 32'h0, 4'b0100);
    send(mk("eq_pass", 1, 3'd0, 1, 4'd10, 0, 0, 0, 0, 32'h0, 2, 1, 0, 4'd3, 4'd4, 4'd0), 1);
    // NV on a PC-writing MOV
    setf(4'hF, 4'hD, 0, 1, 0, 4'd0, 4'd15, 4'd0, 4'd0, 2'd0, 5'd0, 32'h100, 4'b1111);
`ifdef DP_SEQ_COND_EN
    send(mk("nv_fail", 0, 3'd0, 0, 4'd0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 4'd0, 4'd0, 4'd0), 1);
`else
    send(mk("nv_mov_pc", 1, 3'd0, 0, 4'd15, 0, 1, 1, 1, 32'h100, 3, 1, 0, 4'd0, 4'd0, 4'd0), 1);
`endif

    // Reset during EXEC aborts the instruction; nothing is expected from it
    setf(4'hE, 4'h4, 1, 0, 0, 4'd1, 4'd4, 4'd2, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("aborted", 1, 3'd0, 1, 4'd4, 1, 0, 0, 0, 32'h0, 2, 1, 0, 4'd1, 4'd2, 4'd0), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back valid right after the aborting reset
    setf(4'hE, 4'hC, 1, 0, 0, 4'd2, 4'd1, 4'd3, 4'd0, 2'd0, 5'd0, 32'h0, 4'h0);
    send(mk("orr_after_rst", 1, 3'd3, 1, 4'd1, 1, 0, 0, 0, 32'h0, 2, 1, 0, 4'd2, 4'd3, 4'd0), 1);
    setf(4'hE, 4'h1, 0, 1, 0, 4'd5, 4'd12, 4'd6, 4'd0, 2'd0, 5'd0, 32'hAB, 4'h0);
    send(mk("eor_b2b", 1, 3'd4, 1, 4'd12, 0, 0, 0, 1, 32'hAB, 2, 1, 0, 4'd5, 4'd6, 4'd0), 1);

    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n = n + 1;
    end
    repeat (3) @(posedge clk);
    stim_done = 1;
  end

endmodule
